// File: rtl/add_arbiter_if.sv
// Bundle of requester and result-consumer signals for add_arbiter.
// slave  : the arbiter side (takes requests, drives grants and results).
// master : the requester/consumer side (drives requests, consumes results).
interface add_arbiter_if #(
    parameter int W    = 32,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]         IN_valid;
    logic [NREQ-1:0][W-1:0]  IN_dataA;
    logic [NREQ-1:0][W-1:0]  IN_dataB;
    logic [NREQ-1:0]         OUT_ready;
    logic                    OUT_valid;
    logic [W-1:0]            OUT_data;
    logic                    OUT_carry;
    logic [IDW-1:0]          OUT_id;
    logic                    IN_ready;

    modport slave (
        input  IN_valid, IN_dataA, IN_dataB, IN_ready,
        output OUT_ready, OUT_valid, OUT_data, OUT_carry, OUT_id
    );

    modport master (
        output IN_valid, IN_dataA, IN_dataB, IN_ready,
        input  OUT_ready, OUT_valid, OUT_data, OUT_carry, OUT_id
    );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: one shared W-bit adder arbitrated round-robin among NREQ
// requesters, feeding a single registered result slot (EMPTY/FULL) that
// can drain and refill in the same cycle.
// Optional build macro ADD_ARBITER_SAT_EN: when defined, a sum that carries
// out saturates OUT_data to all ones; otherwise OUT_data is the wrapped sum.
module add_arbiter #(
    parameter int W    = 32,
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [W-1:0]    data_q,  data_d;
    logic            carry_q, carry_d;
    logic [IDW-1:0]  id_q,    id_d;

    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic [IDW-1:0]  cand_idx;
    int              cand;
    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [W:0]      sum_full;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr_q) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!win_found && bus.IN_valid[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    // A grant is possible when the slot is empty or is being drained this
    // cycle; held low while reset is asserted.
    assign grant_en = rst_n && win_found && ((state_q == EMPTY) || bus.IN_ready);

    // One-hot grant decode: only the winner sees OUT_ready.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = grant_en && (win_idx == IDW'(gi));
        end
    endgenerate

    assign bus.OUT_ready = grant;

    // Shared adder, computed one bit wider to capture the carry-out.
    assign sum_full = {1'b0, bus.IN_dataA[win_idx]} + {1'b0, bus.IN_dataB[win_idx]};

    // Next-state and result-capture logic for the EMPTY/FULL slot.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        carry_d = carry_q;
        id_d    = id_q;
        if (grant_en) begin
            ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
`ifdef ADD_ARBITER_SAT_EN
            data_d  = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
            data_d  = sum_full[W-1:0];
`endif
            carry_d = sum_full[W];
            id_d    = win_idx;
        end
        case (state_q)
            EMPTY: begin
                if (grant_en) state_d = FULL;
            end
            FULL: begin
                if (!grant_en && bus.IN_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, pointer and result registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            id_q    <= id_d;
        end
    end

    assign bus.OUT_valid = (state_q == FULL);
    assign bus.OUT_data  = data_q;
    assign bus.OUT_carry = carry_q;
    assign bus.OUT_id    = id_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port IN_valid  input  NREQ  per-requester request valid.
REQ-006 The block SHALL have port IN_dataA  input  NREQ x W  per-requester operand A.
REQ-007 The block SHALL have port IN_dataB  input  NREQ x W  per-requester operand B.
REQ-008 The block SHALL have port OUT_ready  output  NREQ  one-hot grant; request i is accepted in a cycle where IN_valid[i] and OUT_ready[i] are both 1.
REQ-009 The block SHALL have port OUT_valid  output  1  result register holds a valid result.
REQ-010 The block SHALL have port OUT_data  output  W  registered sum.
REQ-011 The block SHALL have port OUT_carry  output  1  carry-out of the registered sum.
REQ-012 The block SHALL have port OUT_id  output  $clog2(NREQ)  index of the requester that produced the result.
REQ-013 The block SHALL have port IN_ready  input  1  consumer accepts result when OUT_valid and IN_ready are both 1.

Function
REQ-014 The block SHALL share one W-bit adder among NREQ requesters, at most one grant per cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr, wraps from NREQ-1 to 0, first i with IN_valid[i]=1 wins.
REQ-016 After an accepted request from i, ptr SHALL become (i+1) mod NREQ; without acceptance ptr SHALL hold.
REQ-017 OUT_ready SHALL be combinational, asserted only for the winner and only when the FSM can accept (REQ-019); OUT_ready SHALL NOT depend on IN_valid of non-winners.
REQ-018 FSM states SHALL be EMPTY (OUT_valid=0) and FULL (OUT_valid=1).
REQ-019 A grant SHALL be allowed in EMPTY, or in FULL when IN_ready=1 in the same cycle (pass-through drain and refill).
REQ-020 EMPTY->FULL on acceptance; FULL->EMPTY on IN_ready=1 with no acceptance; FULL->FULL on stall (IN_ready=0) or on simultaneous drain and acceptance.
REQ-021 Latency SHALL be 1 cycle: result of a request accepted in cycle t appears on OUT_* in cycle t+1.
REQ-022 {OUT_carry, OUT_data} SHALL equal IN_dataA[i] + IN_dataB[i] computed at W+1 bits, unsigned.
REQ-023 While OUT_valid=1 and IN_ready=0, OUT_data, OUT_carry, OUT_id SHALL remain stable.
REQ-024 Sustained throughput SHALL be one result per cycle when IN_ready is held 1.
REQ-025 With no IN_valid set, no grant SHALL occur and ptr SHALL hold.

Reset
REQ-026 On rst_n=0, asynchronously: state EMPTY, OUT_valid=0, OUT_data=0, OUT_carry=0, OUT_id=0, ptr=0, OUT_ready=0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard any held result; no result SHALL be emitted after deassertion without a new acceptance.
REQ-028 The first grant after reset deassertion SHALL be no earlier than the first rising edge with rst_n=1.

Configuration
REQ-029 Macro ADD_ARBITER_SAT_EN SHALL select saturation: when defined, a W+1-bit sum with carry=1 SHALL produce OUT_data = all ones and OUT_carry = 1; when undefined, OUT_data SHALL be the wrapped sum modulo 2^W (REQ-022).

Verification
REQ-030 Bench SHALL cover: reset, single request i=2 with A=5,B=7, IN_ready=1 -> next cycle OUT_valid=1, OUT_data=12, OUT_carry=0, OUT_id=2, then OUT_valid=0.
REQ-031 Bench SHALL cover: all four IN_valid=1 held, IN_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-032 Bench SHALL cover: IN_ready=0 for 3 cycles with result 0x10 pending and IN_valid[1]=1 -> OUT_ready=0, OUT_data stable 0x10; on IN_ready=1 same cycle grant to 1, its result next cycle.
REQ-033 Bench SHALL cover: A=0xFFFFFFFF, B=2 -> OUT_data=0x00000001, OUT_carry=1 without macro; OUT_data=0xFFFFFFFF, OUT_carry=1 with ADD_ARBITER_SAT_EN.
REQ-034 Bench SHALL cover: rst_n pulsed low while OUT_valid=1 and IN_ready=0 -> OUT_valid=0 immediately, ptr=0, next grant goes to lowest valid index.
